tile_pattern_gen: RTL and testbench

Parametrised successor to the fixed 8x8 tile colour generator. Maps the active raster onto a COLS x ROWS grid of tiles and fetches each tile's 24-bit colour from an external synchronous palette memory. Adds frame-synchronous horizontal/vertical scrolling driven by KEY, frame-latched display modes from SW, and a fixed-latency registered RGB output. Sits between the VGA timing generator (hPixel, line, video_active, vSync) and the VGA DAC pins.

---
 rtl/tpg_pkg.sv | 31 +++
 rtl/tpg_frame_ctrl.sv | 65 ++++++
 rtl/tile_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_tile_pattern_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpg_pkg.sv
// Shared types and constants for the tile pattern generator.
// Holds the display mode encoding, pipeline depth and RGB field layout.
package tpg_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_HSCROLL = 2'd1,
    MODE_VSCROLL = 2'd2,
    MODE_CHECKER = 2'd3
  } tpg_mode_e;

  localparam int LATENCY = 3;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [23:0] RGB_WHITE = 24'hFF_FFFF;

  // Index width for a counter over n values, never narrower than one bit.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tpg_frame_ctrl.sv
// Frame-synchronous control: vSync rising-edge detect, KEY actions and mode latch.
// Offsets and mode only move on a vSync rising edge, so they are stable for a whole frame.
module tpg_frame_ctrl
  import tpg_pkg::*;
#(
  parameter int COLS = 8,
  parameter int ROWS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic [2:0]               key,
  input  logic [1:0]               sw_mode,
  output logic [idx_w(COLS)-1:0]   hoff,
  output logic [idx_w(ROWS)-1:0]   voff,
  output tpg_mode_e                mode
);

  localparam int CW = idx_w(COLS);
  localparam int RW = idx_w(ROWS);

  logic            vsync_prev_reg;
  logic            vsync_rise;
  logic [CW-1:0]   hoff_reg, hoff_next;
  logic [RW-1:0]   voff_reg, voff_next;
  tpg_mode_e       mode_reg, mode_next;

  assign vsync_rise = vsync & ~vsync_prev_reg;

  // KEY[2] clears both offsets and wins over the advance buttons; KEY[0]/KEY[1] are independent.
  always_comb begin
    hoff_next = hoff_reg;
    voff_next = voff_reg;
    mode_next = mode_reg;
    if (vsync_rise) begin
      mode_next = tpg_mode_e'(sw_mode);
      if (!key[2]) begin
        hoff_next = '0;
        voff_next = '0;
      end else begin
        if (!key[0]) hoff_next = (hoff_reg == CW'(COLS - 1)) ? '0 : hoff_reg + CW'(1);
        if (!key[1]) voff_next = (voff_reg == RW'(ROWS - 1)) ? '0 : voff_reg + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev_reg <= 1'b0;
      hoff_reg       <= '0;
      voff_reg       <= '0;
      mode_reg       <= MODE_STATIC;
    end else begin
      vsync_prev_reg <= vsync;
      hoff_reg       <= hoff_next;
      voff_reg       <= voff_next;
      mode_reg       <= mode_next;
    end
  end

  assign hoff = hoff_reg;
  assign voff = voff_reg;
  assign mode = mode_reg;

endmodule

// File: rtl/tile_pattern_gen.sv
// Maps the raster onto a COLS x ROWS tile grid, fetches tile colours from an external
// synchronous palette and drives the DAC pins with a fixed three-cycle latency.
module tile_pattern_gen
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       hPixel,
  input  logic [31:0]       line,
  input  logic              video_active,
  input  logic              vSync,
  input  logic [2:0]        KEY,
  input  logic [9:0]        SW,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_q,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              active_out
);

  localparam int TILE_W = H_ACTIVE / COLS;
  localparam int TILE_H = V_ACTIVE / ROWS;
  localparam int CW     = idx_w(COLS);
  localparam int RW     = idx_w(ROWS);
  localparam int HSUB_W = idx_w(TILE_W);
  localparam int VSUB_W = idx_w(TILE_H);
  localparam int DEPTH  = LATENCY - 1;
  localparam int LAST   = DEPTH - 1;

  logic [CW-1:0]     hoff, col_reg, col_cur, col_eff, col_scr;
  logic [CW:0]       col_sum;
  logic [RW-1:0]     voff, row_reg, row_cur, row_eff, row_scr;
  logic [RW:0]       row_sum;
  logic [HSUB_W-1:0] hsub_reg, hsub_cur;
  logic [VSUB_W-1:0] vsub_reg, vsub_cur;
  logic [31:0]       line_prev_reg;
  logic              in_view;
  tpg_mode_e         mode;
  logic [ADDR_W-1:0] addr_next;
  logic [23:0]       rgb_sel;
  logic              act_pipe_reg  [DEPTH];
  logic              chk_pipe_reg  [DEPTH];
  tpg_mode_e         mode_pipe_reg [DEPTH];
  logic              unused_sw;

  assign unused_sw = ^SW[9:2];

  tpg_frame_ctrl #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_frame_ctrl (
    .clk     (clk),
    .reset   (reset),
    .vsync   (vSync),
    .key     (KEY),
    .sw_mode (SW[1:0]),
    .hoff    (hoff),
    .voff    (voff),
    .mode    (mode)
  );

  // Sub-tile counters replace the divider: columns step every pixel, rows on each new line.
  always_comb begin
    col_cur  = col_reg;
    hsub_cur = hsub_reg;
    if (hPixel == '0) begin
      col_cur  = '0;
      hsub_cur = '0;
    end else if (hsub_reg == HSUB_W'(TILE_W - 1)) begin
      hsub_cur = '0;
      col_cur  = (col_reg == CW'(COLS - 1)) ? '0 : col_reg + CW'(1);
    end else begin
      hsub_cur = hsub_reg + HSUB_W'(1);
    end
  end

  always_comb begin
    row_cur  = row_reg;
    vsub_cur = vsub_reg;
    if (line == '0) begin
      row_cur  = '0;
      vsub_cur = '0;
    end else if (line != line_prev_reg) begin
      if (vsub_reg == VSUB_W'(TILE_H - 1)) begin
        vsub_cur = '0;
        row_cur  = (row_reg == RW'(ROWS - 1)) ? '0 : row_reg + RW'(1);
      end else begin
        vsub_cur = vsub_reg + VSUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_reg       <= '0;
      hsub_reg      <= '0;
      row_reg       <= '0;
      vsub_reg      <= '0;
      line_prev_reg <= '0;
    end else begin
      col_reg       <= col_cur;
      hsub_reg      <= hsub_cur;
      row_reg       <= row_cur;
      vsub_reg      <= vsub_cur;
      line_prev_reg <= line;
    end
  end

  assign in_view = (hPixel < 32'(H_ACTIVE)) && (line < 32'(V_ACTIVE));
  assign col_eff = in_view ? col_cur : '0;
  assign row_eff = in_view ? row_cur : '0;

  // Both operands are below the modulus, so one conditional subtract is a full wrap.
  always_comb begin
    col_sum = (CW+1)'(col_eff) + (CW+1)'(hoff);
    row_sum = (RW+1)'(row_eff) + (RW+1)'(voff);
    col_scr = (col_sum >= (CW+1)'(COLS)) ? CW'(col_sum - (CW+1)'(COLS)) : CW'(col_sum);
    row_scr = (row_sum >= (RW+1)'(ROWS)) ? RW'(row_sum - (RW+1)'(ROWS)) : RW'(row_sum);
    case (mode)
      MODE_HSCROLL: addr_next = ADDR_W'(row_eff) * ADDR_W'(COLS) + ADDR_W'(col_scr);
      MODE_VSCROLL: addr_next = ADDR_W'(row_scr) * ADDR_W'(COLS) + ADDR_W'(col_eff);
      default:      addr_next = ADDR_W'(row_eff) * ADDR_W'(COLS) + ADDR_W'(col_eff);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        act_pipe_reg[i]  <= 1'b0;
        chk_pipe_reg[i]  <= 1'b0;
        mode_pipe_reg[i] <= MODE_STATIC;
      end
    end else begin
      mem_addr         <= addr_next;
      act_pipe_reg[0]  <= video_active;
      chk_pipe_reg[0]  <= col_eff[0] ^ row_eff[0];
      mode_pipe_reg[0] <= mode;
      for (int i = 1; i < DEPTH; i++) begin
        act_pipe_reg[i]  <= act_pipe_reg[i-1];
        chk_pipe_reg[i]  <= chk_pipe_reg[i-1];
        mode_pipe_reg[i] <= mode_pipe_reg[i-1];
      end
    end
  end

  always_comb begin
    rgb_sel = '0;
    if (act_pipe_reg[LAST]) begin
      if (mode_pipe_reg[LAST] == MODE_CHECKER) rgb_sel = chk_pipe_reg[LAST] ? RGB_WHITE : '0;
      else                                     rgb_sel = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
      active_out <= 1'b0;
    end else begin
      VGA_R      <= rgb_sel[R_HI:R_LO];
      VGA_G      <= rgb_sel[G_HI:G_LO];
      VGA_B      <= rgb_sel[B_HI:B_LO];
      active_out <= act_pipe_reg[LAST];
    end
  end

endmodule

// File: tb/tb_tile_pattern_gen.sv
// Raster-driven bench for tile_pattern_gen: every cycle is compared against a
// frame-level model built from floor division and modular offsets.
module tb_tile_pattern_gen;
  import tpg_pkg::*;

  localparam int HA = 640;
  localparam int VA = 480;
  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam int TW = HA / COLS;
  localparam int TH = VA / ROWS;
  localparam int NLINES = VA + 45;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hPixel, line;
  logic        video_active, vSync;
  logic [2:0]  KEY;
  logic [9:0]  SW;
  logic [5:0]  mem_addr;
  logic [23:0] mem_q;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        active_out;
  logic [23:0] pal [0:63];

  always #5 clk = ~clk;

  always_ff @(posedge clk) mem_q <= pal[mem_addr];

  tile_pattern_gen dut (
    .clk(clk), .reset(reset), .hPixel(hPixel), .line(line),
    .video_active(video_active), .vSync(vSync), .KEY(KEY), .SW(SW),
    .mem_addr(mem_addr), .mem_q(mem_q),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .active_out(active_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: frame state plus a queue of in-flight expectations.
  int          m_mode, m_hoff, m_voff;
  bit          m_vs_prev;
  int          p_key [3];
  logic [23:0] p_rgb [3];
  bit          p_act [3];
  int          p_addr;
  int          cap_addr [int];
  logic [23:0] cap_rgb  [int];
  bit          cap_act  [int];
  bit          full_map [NLINES];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int hx, ly, c, r, a, k;
    bit vis;
    logic [23:0] e_rgb;
    hx  = int'(hPixel);
    ly  = int'(line);
    vis = (hx < HA) && (ly < VA);
    c   = vis ? hx / TW : 0;
    r   = vis ? ly / TH : 0;
    k   = ly * 1024 + hx;
    case (m_mode)
      1:       a = r * COLS + (c + m_hoff) % COLS;
      2:       a = ((r + m_voff) % ROWS) * COLS + c;
      default: a = r * COLS + c;
    endcase
    if (!video_active)    e_rgb = 24'h0;
    else if (m_mode == 3) e_rgb = ((c ^ r) & 1) != 0 ? 24'hFFFFFF : 24'h0;
    else                  e_rgb = pal[a];
    if (reset) begin
      m_mode = 0; m_hoff = 0; m_voff = 0;
    end else if (vSync && !m_vs_prev) begin
      if (!KEY[2]) begin
        m_hoff = 0; m_voff = 0;
      end else begin
        if (!KEY[0]) m_hoff = (m_hoff + 1) % COLS;
        if (!KEY[1]) m_voff = (m_voff + 1) % ROWS;
      end
      m_mode = int'(SW[1:0]);
    end
    m_vs_prev = reset ? 1'b0 : vSync;
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        p_key[i] = -1; p_rgb[i] = 24'h0; p_act[i] = 1'b0;
      end
      p_addr = 0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        p_key[i] = p_key[i-1]; p_rgb[i] = p_rgb[i-1]; p_act[i] = p_act[i-1];
      end
      p_key[0] = k; p_rgb[0] = e_rgb; p_act[0] = video_active; p_addr = a;
    end
    check_eq("mem_addr", mem_addr, p_addr);
    check_eq("rgb", {VGA_R, VGA_G, VGA_B}, p_rgb[2]);
    check_eq("active_out", active_out, p_act[2]);
    if (p_key[0] >= 0) cap_addr[p_key[0]] = int'(mem_addr);
    if (p_key[2] >= 0) begin
      cap_rgb[p_key[2]] = {VGA_R, VGA_G, VGA_B};
      cap_act[p_key[2]] = active_out;
    end
  endtask

  function automatic logic [31:0] got_addr(int x, int y);
    return cap_addr.exists(y * 1024 + x) ? 32'(cap_addr[y * 1024 + x]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] got_rgb(int x, int y);
    return cap_rgb.exists(y * 1024 + x) ? 32'(cap_rgb[y * 1024 + x]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] got_act(int x, int y);
    return cap_act.exists(y * 1024 + x) ? 32'(cap_act[y * 1024 + x]) : 32'hDEAD_BEEF;
  endfunction

  task automatic drive(input int x, input int y, input bit v);
    hPixel = 32'(x); line = 32'(y); video_active = v;
    tick();
  endtask

  task automatic run_line(input int y, input bit full, input bit v_en);
    if (full) begin
      for (int x = 0; x < HA; x++) drive(x, y, v_en && (y < VA));
      for (int x = HA; x < HA + 20; x++) drive(x, y, 1'b0);
    end else begin
      drive(0, y, v_en && (y < VA));
    end
  endtask

  task automatic frame(input int chg_line, input logic [1:0] sw_after);
    cap_addr.delete(); cap_rgb.delete(); cap_act.delete();
    for (int y = 0; y < NLINES; y++) begin
      if (y == chg_line) SW[1:0] = sw_after;
      vSync = (y == 490) || (y == 491);
      run_line(y, full_map[y], 1'b1);
    end
    vSync = 1'b0;
  endtask

  task automatic clear_full(input int n_rand);
    foreach (full_map[i]) full_map[i] = 1'b0;
    for (int i = 0; i < n_rand; i++) full_map[$urandom_range(0, VA - 1)] = 1'b1;
  endtask

  task automatic idle(input int n);
    hPixel = 32'(HA); line = 32'(VA + 10); video_active = 1'b0; vSync = 1'b0;
    repeat (n) tick();
  endtask

  task automatic vsync_pulses(input int n);
    hPixel = 32'(HA); line = 32'(VA + 10); video_active = 1'b0;
    repeat (n) begin
      vSync = 1'b1; tick(); tick();
      vSync = 1'b0; tick(); tick();
    end
  endtask

  initial begin
    foreach (pal[i]) pal[i] = 24'(i);
    m_mode = 0; m_hoff = 0; m_voff = 0; m_vs_prev = 1'b0; p_addr = 0;
    for (int i = 0; i < 3; i++) begin
      p_key[i] = -1; p_rgb[i] = 24'h0; p_act[i] = 1'b0;
    end
    reset = 1'b1; KEY = 3'b111; SW = 10'h0;
    hPixel = 32'(HA); line = 32'(VA + 10); video_active = 1'b0; vSync = 1'b0;
    tick(); tick();
    check_eq("reset_active_out", active_out, 32'd0);
    reset = 1'b0;
    idle(3);

    // STATIC with identity palette: corners and tile boundaries
    clear_full(1);
    full_map[0] = 1'b1; full_map[59] = 1'b1; full_map[60] = 1'b1; full_map[479] = 1'b1;
    frame(-1, 2'b00);
    check_eq("static_addr_0_0", got_addr(0, 0), 32'd0);
    check_eq("static_rgb_0_0", got_rgb(0, 0), 32'd0);
    check_eq("static_act_0_0", got_act(0, 0), 32'd1);
    check_eq("static_addr_639_479", got_addr(639, 479), 32'd63);
    check_eq("static_addr_79_59", got_addr(79, 59), 32'd0);
    check_eq("static_addr_80_59", got_addr(80, 59), 32'd1);
    check_eq("static_addr_0_59", got_addr(0, 59), 32'd0);
    check_eq("static_addr_0_60", got_addr(0, 60), 32'd8);
    check_eq("static_addr_80_60", got_addr(80, 60), 32'd9);
    check_eq("static_rgb_80_60", got_rgb(80, 60), 32'd9);

    foreach (pal[i]) pal[i] = 24'($urandom());

    // HSCROLL: nine advances wrap hoff to 1
    KEY = 3'b110; SW[1:0] = 2'b01;
    vsync_pulses(9);
    KEY = 3'b111;
    clear_full(1); full_map[0] = 1'b1;
    frame(-1, 2'b00);
    check_eq("hscroll_addr_0_0", got_addr(0, 0), 32'd1);
    check_eq("hscroll_addr_560_0", got_addr(560, 0), 32'd0);

    // VSCROLL with voff = 7
    KEY = 3'b101; SW[1:0] = 2'b10;
    vsync_pulses(7);
    KEY = 3'b111;
    clear_full(1); full_map[0] = 1'b1; full_map[60] = 1'b1;
    frame(-1, 2'b00);
    check_eq("vscroll_addr_0_0", got_addr(0, 0), 32'd56);
    check_eq("vscroll_addr_0_60", got_addr(0, 60), 32'd0);

    // KEY[2] overrides KEY[0]; SW change mid-frame waits for the next edge
    KEY = 3'b010; SW[1:0] = 2'b01;
    vsync_pulses(1);
    KEY = 3'b111;
    clear_full(0); full_map[0] = 1'b1; full_map[200] = 1'b1;
    frame(100, 2'b11);
    check_eq("clear_addr_0_0", got_addr(0, 0), 32'd0);
    check_eq("midsw_addr_80_200", got_addr(80, 200), 32'd25);
    check_eq("midsw_rgb_80_200", got_rgb(80, 200), 32'(pal[25]));

    // CHECKER
    clear_full(1); full_map[0] = 1'b1; full_map[60] = 1'b1;
    frame(-1, 2'b00);
    check_eq("checker_rgb_0_0", got_rgb(0, 0), 32'd0);
    check_eq("checker_rgb_80_0", got_rgb(80, 0), 32'hFFFFFF);
    check_eq("checker_rgb_80_60", got_rgb(80, 60), 32'd0);
    check_eq("checker_act_80_60", got_act(80, 60), 32'd1);

    // Visible coordinates with video_active low stay black
    cap_addr.delete(); cap_rgb.delete(); cap_act.delete();
    run_line(0, 1'b1, 1'b0);
    check_eq("inactive_rgb_80_0", got_rgb(80, 0), 32'd0);
    check_eq("inactive_act_80_0", got_act(80, 0), 32'd0);

    // Reset in the middle of a white checker run
    for (int x = 0; x <= 100; x++) drive(x, 0, 1'b1);
    hPixel = 32'd101; reset = 1'b1;
    tick();
    check_eq("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 32'd0);
    check_eq("midrst_active_out", active_out, 32'd0);
    check_eq("midrst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    idle(4);

    // Random keys, modes and sampled lines
    for (int f = 0; f < 4; f++) begin
      KEY = 3'($urandom());
      SW  = 10'($urandom());
      clear_full(3);
      frame(-1, 2'b00);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
